// File: rtl/apu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// apu_frame_sequencer
// APU frame sequencer. A divider produces a step tick every STEP_DIV clocks.
// The step index walks a 4-step or 5-step sequence. Each tick can emit a
// quarter-frame pulse, a half-frame pulse and the frame interrupt.
//
// Ports
//   clk          APU clock, rising-edge active
//   reset        synchronous active-high reset
//   mode_wr      one-cycle strobe, writes mode_data to the mode register
//   mode_data    [7] 5-step mode, [6] IRQ inhibit, [5:0] ignored
//   irq_ack      one-cycle strobe, clears irq
//   enable_240hz registered quarter-frame pulse (envelopes, linear counter)
//   enable_120hz registered half-frame pulse (length counters, sweeps)
//   irq          registered frame-interrupt level
//   step         current sequencer step index
// ---------------------------------------------------------------------------
module apu_frame_sequencer #(
    parameter int unsigned CLKRATE  = 1_790_000,
    parameter int unsigned STEPRATE = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_wr,
    input  logic [7:0] mode_data,
    input  logic       irq_ack,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       irq,
    output logic [2:0] step
);

    localparam int unsigned STEP_DIV = CLKRATE / STEPRATE;
    localparam int unsigned CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

    typedef enum logic {
        SEQ_4STEP = 1'b0,
        SEQ_5STEP = 1'b1
    } seq_mode_e;

    typedef enum logic [2:0] {
        STEP_0 = 3'd0,
        STEP_1 = 3'd1,
        STEP_2 = 3'd2,
        STEP_3 = 3'd3,
        STEP_4 = 3'd4
    } step_e;

    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    step_e            step_q, step_nxt;
    seq_mode_e        mode_q, mode_nxt;
    logic             inhibit_q, inhibit_nxt;
    logic             irq_nxt;
    logic             quarter_nxt, half_nxt;
    logic             tick_c;
    logic             mode_data_unused;

    // Low mode bits carry no meaning for the sequencer.
    assign mode_data_unused = ^mode_data[5:0];

    assign step = step_q;

    // A mode write in the same cycle as the divider terminal count swallows the tick.
    assign tick_c = (cnt_q == CNT_MAX) && !mode_wr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            step_q       <= STEP_0;
            mode_q       <= SEQ_4STEP;
            inhibit_q    <= 1'b0;
            irq          <= 1'b0;
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;
        end else begin
            cnt_q        <= cnt_nxt;
            step_q       <= step_nxt;
            mode_q       <= mode_nxt;
            inhibit_q    <= inhibit_nxt;
            irq          <= irq_nxt;
            enable_240hz <= quarter_nxt;
            enable_120hz <= half_nxt;
        end
    end

    // Next-state and pulse decode.
    always_comb begin
        cnt_nxt     = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        step_nxt    = step_q;
        mode_nxt    = mode_q;
        inhibit_nxt = inhibit_q;
        irq_nxt     = irq;
        quarter_nxt = 1'b0;
        half_nxt    = 1'b0;

        // The acknowledge is applied first so a coincident step-3 set overrides it.
        if (irq_ack) begin
            irq_nxt = 1'b0;
        end

        if (mode_wr) begin
            mode_nxt    = seq_mode_e'(mode_data[7]);
            inhibit_nxt = mode_data[6];
            cnt_nxt     = '0;
            step_nxt    = STEP_0;
            if (mode_data[7]) begin
                quarter_nxt = 1'b1;
                half_nxt    = 1'b1;
            end
            if (mode_data[6]) begin
                irq_nxt = 1'b0;
            end
        end else if (tick_c) begin
            case (step_q)
                STEP_0: begin
                    quarter_nxt = 1'b1;
                    step_nxt    = STEP_1;
                end
                STEP_1: begin
                    quarter_nxt = 1'b1;
                    half_nxt    = 1'b1;
                    step_nxt    = STEP_2;
                end
                STEP_2: begin
                    quarter_nxt = 1'b1;
                    step_nxt    = STEP_3;
                end
                STEP_3: begin
                    // 5-step mode inserts a silent step here.
                    if (mode_q == SEQ_5STEP) begin
                        step_nxt = STEP_4;
                    end else begin
                        quarter_nxt = 1'b1;
                        half_nxt    = 1'b1;
                        step_nxt    = STEP_0;
                        if (!inhibit_q) begin
                            irq_nxt = 1'b1;
                        end
                    end
                end
                STEP_4: begin
                    quarter_nxt = 1'b1;
                    half_nxt    = 1'b1;
                    step_nxt    = STEP_0;
                end
                default: begin
                    step_nxt = STEP_0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apu_frame_sequencer
// Directed bench for apu_frame_sequencer with STEP_DIV = 10. The stimulus
// pushes expected pulses and probe points into queues, keyed by clock-edge
// number. The monitor samples on the falling edge and compares against them.
// ---------------------------------------------------------------------------
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_wr;
    logic [7:0] mode_data;
    logic       irq_ack;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       irq;
    logic [2:0] step;

    apu_frame_sequencer #(
        .CLKRATE  (40),
        .STEPRATE (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_wr      (mode_wr),
        .mode_data    (mode_data),
        .irq_ack      (irq_ack),
        .enable_240hz (enable_240hz),
        .enable_120hz (enable_120hz),
        .irq          (irq),
        .step         (step)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        half;
        logic [2:0]  step;
        logic        irq;
    } pulse_t;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  step;
        logic        irq;
    } probe_t;

    pulse_t pq[$];
    probe_t iq[$];
    pulse_t mon_e;
    probe_t mon_p;

    int checks = 0;
    int errors = 0;

    task automatic exp_pulse(input int unsigned c, input logic h, input logic [2:0] s,
                             input logic i);
        pulse_t e;
        e.cyc  = c;
        e.half = h;
        e.step = s;
        e.irq  = i;
        pq.push_back(e);
    endtask

    task automatic exp_probe(input int unsigned c, input logic [2:0] s, input logic i);
        probe_t p;
        p.cyc  = c;
        p.step = s;
        p.irq  = i;
        iq.push_back(p);
    endtask

    // One full 4-step period starting from a counter restart at edge 'base'.
    task automatic exp_4step(input int unsigned base, input logic irq_end);
        exp_pulse(base + 10, 1'b0, 3'd1, 1'b0);
        exp_pulse(base + 20, 1'b1, 3'd2, 1'b0);
        exp_pulse(base + 30, 1'b0, 3'd3, 1'b0);
        exp_pulse(base + 40, 1'b1, 3'd0, irq_end);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            mon_e = pq.pop_front();
            checks++;
            if ({enable_240hz, enable_120hz, step, irq} !== {1'b1, mon_e.half, mon_e.step, mon_e.irq}) begin
                errors++;
                $display("FAIL pulse@%0d: got e240=%b e120=%b step=%0d irq=%b, want e240=1 e120=%b step=%0d irq=%b",
                         cyc, enable_240hz, enable_120hz, step, irq, mon_e.half, mon_e.step, mon_e.irq);
            end
        end else if (enable_240hz || enable_120hz) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse@%0d: got e240=%b e120=%b step=%0d, want no pulse",
                     cyc, enable_240hz, enable_120hz, step);
        end
        if (iq.size() > 0 && iq[0].cyc == cyc) begin
            mon_p = iq.pop_front();
            checks++;
            if ({step, irq} !== {mon_p.step, mon_p.irq}) begin
                errors++;
                $display("FAIL probe@%0d: got step=%0d irq=%b, want step=%0d irq=%b",
                         cyc, step, irq, mon_p.step, mon_p.irq);
            end
        end
    end

    int unsigned b, c2, c3, c4, r;

    initial begin
        reset     = 1'b1;
        mode_wr   = 1'b0;
        mode_data = 8'h00;
        irq_ack   = 1'b0;

        // Reset state.
        exp_probe(3, 3'd0, 1'b0);
        @(negedge clk);
        wait_until(5);

        // Release: 4-step period, irq at the end.
        b     = cyc;
        reset = 1'b0;
        exp_probe(b + 5, 3'd0, 1'b0);
        exp_4step(b, 1'b1);
        exp_probe(b + 41, 3'd0, 1'b1);

        // Acknowledge clears irq next cycle.
        wait_until(b + 45);
        exp_probe(b + 46, 3'd0, 1'b0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        exp_4step(b + 40, 1'b1);
        exp_probe(b + 81, 3'd0, 1'b1);

        // Acknowledge coincident with the step-3 tick: set wins.
        wait_until(b + 79);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;

        // Inhibit write clears irq and blocks it for three periods.
        wait_until(b + 85);
        c2        = cyc;
        mode_wr   = 1'b1;
        mode_data = 8'h40;
        exp_probe(c2 + 1, 3'd0, 1'b0);
        @(negedge clk);
        mode_wr = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_pulse(c2 + 1 + 10 * (k + 1), (k % 4 == 1) || (k % 4 == 3), 3'((k + 1) % 4), 1'b0);
        end

        // Re-enable: irq sets again after one full period.
        wait_until(c2 + 125);
        c3        = cyc;
        mode_wr   = 1'b1;
        mode_data = 8'h00;
        @(negedge clk);
        mode_wr = 1'b0;
        exp_4step(c3 + 1, 1'b1);
        wait_until(c3 + 45);
        exp_probe(c3 + 46, 3'd0, 1'b0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;

        // 5-step write: immediate double pulse, silent step 3, no irq.
        wait_until(c3 + 47);
        c4        = cyc;
        mode_wr   = 1'b1;
        mode_data = 8'h80;
        exp_pulse(c4 + 1, 1'b1, 3'd0, 1'b0);
        @(negedge clk);
        mode_wr = 1'b0;
        exp_pulse(c4 + 11, 1'b0, 3'd1, 1'b0);
        exp_pulse(c4 + 21, 1'b1, 3'd2, 1'b0);
        exp_pulse(c4 + 31, 1'b0, 3'd3, 1'b0);
        exp_probe(c4 + 42, 3'd4, 1'b0);
        exp_pulse(c4 + 51, 1'b1, 3'd0, 1'b0);

        // Mode write on the terminal count: tick discarded, step back to 0.
        wait_until(c4 + 60);
        mode_wr   = 1'b1;
        mode_data = 8'h00;
        exp_probe(c4 + 61, 3'd0, 1'b0);
        @(negedge clk);
        mode_wr = 1'b0;
        exp_pulse(c4 + 71, 1'b0, 3'd1, 1'b0);
        exp_pulse(c4 + 81, 1'b1, 3'd2, 1'b0);

        // Reset on a tick edge together with a 5-step write: nothing fires, mode stays 4-step.
        wait_until(c4 + 90);
        reset     = 1'b1;
        mode_wr   = 1'b1;
        mode_data = 8'h80;
        exp_probe(c4 + 91, 3'd0, 1'b0);
        @(negedge clk);
        mode_wr = 1'b0;
        @(negedge clk);
        r     = cyc;
        reset = 1'b0;
        exp_4step(r, 1'b1);

        wait_until(r + 45);
        checks++;
        if (pq.size() != 0 || iq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got pulses=%0d probes=%0d pending, want 0 and 0",
                     pq.size(), iq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 SHALL have parameter CLKRATE, default 1_790_000, meaning APU clock frequency in Hz.
REQ-002 SHALL have parameter STEPRATE, default 240, meaning sequencer step frequency in Hz.
REQ-003 SHALL derive STEP_DIV = CLKRATE/STEPRATE (integer division), i.e. 7458 at defaults; STEP_DIV >= 2 is legal.
REQ-004 clk  input  1  APU clock; the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode_wr  input  1  one-cycle strobe; writes mode_data to the mode register.
REQ-007 mode_data  input  8  bit7 = 5-step mode (0 = 4-step); bit6 = IRQ inhibit; bits 5:0 ignored.
REQ-008 irq_ack  input  1  one-cycle strobe; clears irq.
REQ-009 enable_240hz  output  1  registered one-cycle quarter-frame pulse to the channel envelopes and linear counter.
REQ-010 enable_120hz  output  1  registered one-cycle half-frame pulse to the length counters and sweep units.
REQ-011 irq  output  1  registered frame-interrupt level.
REQ-012 step  output  3  current sequencer step index, 0..3 in 4-step mode, 0..4 in 5-step mode.

Function
REQ-013 SHALL hold a divider cnt counting 0..STEP_DIV-1; it increments every cycle and wraps to 0 after STEP_DIV-1.
REQ-014 A "tick" SHALL occur in any cycle where cnt == STEP_DIV-1 and mode_wr is low.
REQ-015 On a tick, step SHALL advance by 1 on the same edge; it wraps to 0 after 3 (4-step) or after 4 (5-step).
REQ-016 4-step mode: a tick at step 0,1,2,3 SHALL pulse enable_240hz on the following cycle; a tick at step 1 or 3 SHALL also pulse enable_120hz.
REQ-017 4-step mode: a tick at step 3 SHALL set irq on the following cycle unless inhibit = 1.
REQ-018 5-step mode: a tick at step 0,1,2,4 SHALL pulse enable_240hz; a tick at step 1 or 4 SHALL also pulse enable_120hz; a tick at step 3 SHALL pulse neither; irq SHALL never be set.
REQ-019 Enable pulses SHALL be exactly one cycle wide. enable_120hz SHALL only ever assert together with enable_240hz.
REQ-020 mode_wr SHALL, on the same edge: latch mode and inhibit; reset cnt and step to 0; discard any coincident tick.
REQ-021 mode_wr with bit7 = 1 SHALL pulse enable_240hz and enable_120hz together on the next cycle. Bit7 = 0 SHALL produce no pulse.
REQ-022 mode_wr with bit6 = 1 SHALL clear irq on the next cycle.
REQ-023 irq_ack SHALL clear irq on the next cycle.
REQ-024 If irq set (REQ-017) and irq_ack occur in the same cycle, set SHALL win.
REQ-025 irq SHALL stay high until it is cleared by irq_ack, an inhibit write or reset.
REQ-026 A mode change between steps SHALL take effect from step 0, with no partial sequence.
REQ-027 The period SHALL be 4*STEP_DIV cycles in 4-step mode and 5*STEP_DIV cycles in 5-step mode; there SHALL be no drift.

Reset
REQ-028 While reset is high: cnt=0, step=0, mode=4-step, inhibit=0, irq=0, enable_240hz=0, enable_120hz=0.
REQ-029 reset SHALL take priority over mode_wr and irq_ack in the same cycle.
REQ-030 Reset asserted mid-sequence SHALL suppress any pending pulse. The first tick after reset release SHALL occur STEP_DIV cycles after release.

Verification (bench uses CLKRATE=40, STEPRATE=4, so STEP_DIV=10)
REQ-031 Reset release, 4-step, 40 cycles:
- enable_240hz pulses at cycles 10,20,30,40.
- enable_120hz pulses at cycles 20,40.
- irq rises at cycle 40; step sequence 0,1,2,3,0.
REQ-032 mode_wr with 0x80 at cycle 5:
- enable_240hz and enable_120hz pulse at cycle 6.
- Then quarter pulses at cycles 16,26,36,56; half pulses at 26,56; no pulse at 46; irq stays 0.
REQ-033 irq high, irq_ack strobed: irq = 0 next cycle. Then irq_ack driven in the same cycle as a step-3 tick: irq remains 1.
REQ-034 mode_wr with 0x40: irq cleared next cycle, no irq across 3 full periods. Then mode_wr with 0x00: irq sets again after 40 cycles.
REQ-035 mode_wr coincident with cnt == 9: no tick pulse and step = 0. Reset coincident with mode_wr 0x80: no pulse and mode stays 4-step.
